// File: rtl/axi_stream_cut_pipe.sv
// AXI4-Stream register chain of NumStages cut stages (full / forward / backward), with flush and occupancy.
// Optional AXI_STREAM_CUT_PIPE_STATS_EN adds saturating tx beat and stall counters.

typedef struct packed {
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic [3:0]  tkeep;
  logic        tlast;
  logic [3:0]  tid;
  logic [3:0]  tdest;
  logic [3:0]  tuser;
} axi_stream_cut_pipe_chan_t;

typedef struct packed {
  axi_stream_cut_pipe_chan_t t;
  logic                      tvalid;
} axi_stream_cut_pipe_req_t;

typedef struct packed {
  logic tready;
} axi_stream_cut_pipe_rsp_t;

module axi_stream_cut_pipe #(
  parameter int unsigned NumStages = 1,
  parameter int unsigned Mode      = 0,
  parameter type s_chan_t          = axi_stream_cut_pipe_chan_t,
  parameter type axi_stream_req_t  = axi_stream_cut_pipe_req_t,
  parameter type axi_stream_rsp_t  = axi_stream_cut_pipe_rsp_t,
  localparam int unsigned OccWidth = (NumStages == 0) ? 1 : $clog2(2 * NumStages + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  axi_stream_req_t     rx_req_i,
  output axi_stream_rsp_t     rx_rsp_o,
  output axi_stream_req_t     tx_req_o,
  input  axi_stream_rsp_t     tx_rsp_i,
  output logic [OccWidth-1:0] occupancy_o
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
  ,
  output logic [31:0]         beat_cnt_o,
  output logic [31:0]         stall_cnt_o
`endif
);

  localparam int unsigned FcntN = (NumStages == 0) ? 1 : NumStages;

  // Link k is the input of stage k; link NumStages is the tx side.
  logic       vld  [NumStages+1];
  logic       rdy  [NumStages+1];
  s_chan_t    dat  [NumStages+1];
  logic [1:0] fcnt [FcntN];

  logic                flush_eff;
  logic [OccWidth-1:0] occ_sum;

  assign flush_eff = (NumStages != 0) && flush_i;

  // Gating both ends during flush blocks every handshake, so the interior
  // can keep shuffling freely; it is all emptied on the next edge anyway.
  assign vld[0]         = rx_req_i.tvalid && !flush_eff;
  assign dat[0]         = rx_req_i.t;
  assign rdy[NumStages] = tx_rsp_i.tready && !flush_eff;

  always_comb begin
    rx_rsp_o        = '0;
    rx_rsp_o.tready = rdy[0] && !flush_eff;
    tx_req_o        = '0;
    tx_req_o.t      = dat[NumStages];
    tx_req_o.tvalid = vld[NumStages] && !flush_eff;
  end

  if (NumStages == 0) begin : g_wire
    assign fcnt[0] = '0;
  end

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    if (Mode == 1) begin : g_fwd
      logic    r_full;
      s_chan_t r_q;
      logic    in_hs, out_hs;

      assign rdy[k]   = !r_full || rdy[k+1];
      assign vld[k+1] = r_full;
      assign dat[k+1] = r_q;
      assign in_hs    = vld[k] && rdy[k];
      assign out_hs   = vld[k+1] && rdy[k+1];
      assign fcnt[k]  = {1'b0, r_full};

      always_ff @(posedge clk_i) begin
        if (rst_i || flush_eff) r_full <= 1'b0;
        else if (in_hs)         r_full <= 1'b1;
        else if (out_hs)        r_full <= 1'b0;
      end

      always_ff @(posedge clk_i) begin
        if (in_hs) r_q <= dat[k];
      end
    end else if (Mode == 2) begin : g_bwd
      logic    s_full;
      s_chan_t s_q;
      logic    capture;

      assign rdy[k]   = !s_full;
      assign vld[k+1] = s_full || vld[k];
      assign dat[k+1] = s_full ? s_q : dat[k];
      assign capture  = vld[k] && !rdy[k+1] && !s_full;
      assign fcnt[k]  = {1'b0, s_full};

      always_ff @(posedge clk_i) begin
        if (rst_i || flush_eff)      s_full <= 1'b0;
        else if (s_full && rdy[k+1]) s_full <= 1'b0;
        else if (capture)            s_full <= 1'b1;
      end

      always_ff @(posedge clk_i) begin
        if (capture) s_q <= dat[k];
      end
    end else begin : g_full
      logic    a_full, b_full;
      s_chan_t a_q, b_q;
      logic    in_hs, out_hs;

      assign rdy[k]   = !b_full;
      assign vld[k+1] = a_full;
      assign dat[k+1] = a_q;
      assign in_hs    = vld[k] && rdy[k];
      assign out_hs   = vld[k+1] && rdy[k+1];
      assign fcnt[k]  = {1'b0, a_full} + {1'b0, b_full};

      // in_hs implies !b_full, so a skid refill and a new accept never coincide.
      always_ff @(posedge clk_i) begin
        if (rst_i || flush_eff) begin
          a_full <= 1'b0;
          b_full <= 1'b0;
        end else if (out_hs) begin
          if (b_full) begin
            a_full <= 1'b1;
            b_full <= 1'b0;
          end else begin
            a_full <= in_hs;
          end
        end else if (in_hs) begin
          if (!a_full) a_full <= 1'b1;
          else         b_full <= 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (out_hs && b_full)                a_q <= b_q;
        else if (in_hs && (!a_full || out_hs)) a_q <= dat[k];
        else if (in_hs)                      b_q <= dat[k];
      end
    end
  end

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < NumStages; k++) occ_sum = occ_sum + OccWidth'(fcnt[k]);
  end

  assign occupancy_o = occ_sum;

`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
  logic [31:0] beat_q, stall_q;
  logic        tx_hs, tx_stall;

  assign tx_hs    = tx_req_o.tvalid && tx_rsp_i.tready;
  assign tx_stall = tx_req_o.tvalid && !tx_rsp_i.tready;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_eff) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (tx_hs && (beat_q != '1))     beat_q  <= beat_q + 32'd1;
      if (tx_stall && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign beat_cnt_o  = beat_q;
  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_axi_stream_cut_pipe.sv
// Directed bench for axi_stream_cut_pipe: four configurations driven one after another.
// Counter checks are compiled in only with AXI_STREAM_CUT_PIPE_STATS_EN.
module tb_axi_stream_cut_pipe;

  typedef struct packed {
    logic [15:0] tdata;
    logic [1:0]  tstrb;
    logic [1:0]  tkeep;
    logic        tlast;
    logic [2:0]  tid;
    logic [3:0]  tdest;
    logic [3:0]  tuser;
  } chan_t;

  typedef struct packed {
    chan_t t;
    logic  tvalid;
  } req_t;

  typedef struct packed {
    logic tready;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush1, flush3;
  int   checks   = 0;
  int   failures = 0;

  req_t rx0, tx0, rx1, tx1, rx2, tx2, rx3, tx3;
  rsp_t rr0, tr0, rr1, tr1, rr2, tr2, rr3, tr3;
  logic [2:0] occ0, occ1, occ3;
  logic [1:0] occ2;
  logic [31:0] bc [4];
  logic [31:0] sc [4];

  axi_stream_cut_pipe #(.NumStages(3), .Mode(0), .s_chan_t(chan_t), .axi_stream_req_t(req_t),
    .axi_stream_rsp_t(rsp_t)) u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .rx_req_i(rx0), .rx_rsp_o(rr0),
    .tx_req_o(tx0), .tx_rsp_i(tr0), .occupancy_o(occ0)
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    , .beat_cnt_o(bc[0]), .stall_cnt_o(sc[0])
`endif
  );

  axi_stream_cut_pipe #(.NumStages(2), .Mode(0), .s_chan_t(chan_t), .axi_stream_req_t(req_t),
    .axi_stream_rsp_t(rsp_t)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush1), .rx_req_i(rx1), .rx_rsp_o(rr1),
    .tx_req_o(tx1), .tx_rsp_i(tr1), .occupancy_o(occ1)
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    , .beat_cnt_o(bc[1]), .stall_cnt_o(sc[1])
`endif
  );

  axi_stream_cut_pipe #(.NumStages(1), .Mode(2), .s_chan_t(chan_t), .axi_stream_req_t(req_t),
    .axi_stream_rsp_t(rsp_t)) u2 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .rx_req_i(rx2), .rx_rsp_o(rr2),
    .tx_req_o(tx2), .tx_rsp_i(tr2), .occupancy_o(occ2)
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    , .beat_cnt_o(bc[2]), .stall_cnt_o(sc[2])
`endif
  );

  axi_stream_cut_pipe #(.NumStages(2), .Mode(1), .s_chan_t(chan_t), .axi_stream_req_t(req_t),
    .axi_stream_rsp_t(rsp_t)) u3 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush3), .rx_req_i(rx3), .rx_rsp_o(rr3),
    .tx_req_o(tx3), .tx_rsp_i(tr3), .occupancy_o(occ3)
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    , .beat_cnt_o(bc[3]), .stall_cnt_o(sc[3])
`endif
  );

  // Beat n carries distinct content in every field, so a field-level mixup shows.
  function automatic chan_t mk(input int n);
    chan_t c;
    c.tdata = n[15:0];
    c.tstrb = n[1:0];
    c.tkeep = ~n[1:0];
    c.tlast = (n % 5 == 4);
    c.tid   = n[4:2];
    c.tdest = n[3:0];
    c.tuser = 4'(n * 3);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int sent, rcv, cyc, first_acc, first_tx, last_tx, ord_err, occ_err, stall_left;

    rst = 1'b1; flush1 = 1'b0; flush3 = 1'b0;
    rx0 = '0; rx1 = '0; rx2 = '0; rx3 = '0;
    tr0 = '0; tr1 = '0; tr2 = '0; tr3 = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_tvalid", 32'(tx1.tvalid), 32'd0);
    chk("rst_occ", 32'(occ1), 32'd0);
    chk("rst_rdy_m0", 32'(rr1.tready), 32'd1);
    chk("rst_rdy_m1", 32'(rr3.tready), 32'd1);
    chk("rst_rdy_m2", 32'(rr2.tready), 32'd1);
    rst = 1'b0;

    // Mode 0, 3 stages, tready=1, 100 back-to-back beats.
    tr0.tready = 1'b1;
    sent = 0; rcv = 0; first_acc = -1; first_tx = -1; last_tx = 0; ord_err = 0; occ_err = 0;
    for (cyc = 0; cyc < 300 && rcv < 100; cyc++) begin
      rx0.tvalid = (sent < 100);
      rx0.t      = mk(sent);
      @(negedge clk);
      if (first_acc >= 0 && cyc >= first_acc + 3 && cyc <= first_acc + 100 && occ0 !== 3'd3)
        occ_err++;
      if (rx0.tvalid && rr0.tready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      if (tx0.tvalid && tr0.tready) begin
        if (tx0.t !== mk(rcv)) ord_err++;
        if (first_tx < 0) first_tx = cyc;
        last_tx = cyc;
        rcv++;
      end
      @(posedge clk); #1;
    end
    rx0.tvalid = 1'b0;
    chk("m0_beats_out", 32'(rcv), 32'd100);
    chk("m0_order", 32'(ord_err), 32'd0);
    chk("m0_latency", 32'(first_tx - first_acc), 32'd3);
    chk("m0_no_bubbles", 32'(last_tx - first_tx), 32'd99);
    chk("m0_occ_steady", 32'(occ_err), 32'd0);
    chk("m0_occ_drained", 32'(occ0), 32'd0);

    // Mode 0, 2 stages, tready=0, continuous rx: fills to 4 then back-pressures.
    tr1.tready = 1'b0;
    sent = 0;
    for (int i = 0; i < 8; i++) begin
      rx1.tvalid = 1'b1;
      rx1.t      = mk(sent);
      @(negedge clk);
      if (rr1.tready) sent++;
      @(posedge clk); #1;
    end
    rx1.t = mk(sent);
    @(negedge clk);
    chk("m0_full_accepts", 32'(sent), 32'd4);
    chk("m0_full_rdy", 32'(rr1.tready), 32'd0);
    chk("m0_full_occ", 32'(occ1), 32'd4);
    @(posedge clk); #1;
    tr1.tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("m0_release_valid", 32'(tx1.tvalid), 32'd1);
      chk("m0_release_beat", tx1.t, mk(i));
      if (rr1.tready) sent++;
      @(posedge clk); #1;
      rx1.t = mk(sent);
    end
    rx1.tvalid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Flush on u1 also clears its counters.
    flush1 = 1'b1;
    @(posedge clk); #1;
    flush1 = 1'b0;
    chk("m0_flush_occ", 32'(occ1), 32'd0);
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    chk("flush_beat_cnt", bc[1], 32'd0);
    chk("flush_stall_cnt", sc[1], 32'd0);
`endif

    // Mode 2, 1 stage: zero latency, one beat held on a single-cycle stall.
    rx2.tvalid = 1'b1; rx2.t = mk(16); tr2.tready = 1'b1;
    @(negedge clk);
    chk("m2_lat0_valid", 32'(tx2.tvalid), 32'd1);
    chk("m2_lat0_data", tx2.t, mk(16));
    chk("m2_lat0_rdy", 32'(rr2.tready), 32'd1);
    @(posedge clk); #1;
    rx2.t = mk(17); tr2.tready = 1'b0;
    @(posedge clk); #1;
    rx2.t = mk(18); tr2.tready = 1'b1;
    @(negedge clk);
    chk("m2_hold_occ", 32'(occ2), 32'd1);
    chk("m2_hold_rdy", 32'(rr2.tready), 32'd0);
    chk("m2_hold_data", tx2.t, mk(17));
    @(posedge clk); #1;
    @(negedge clk);
    chk("m2_resume_occ", 32'(occ2), 32'd0);
    chk("m2_resume_data", tx2.t, mk(18));
    @(posedge clk); #1;
    rx2.tvalid = 1'b0;

    // Mode 1, 2 stages: load two beats, flush with rx valid and tx ready both high.
    rx3.tvalid = 1'b1; rx3.t = mk(32); tr3.tready = 1'b0;
    @(posedge clk); #1;
    rx3.t = mk(33);
    @(posedge clk); #1;
    rx3.tvalid = 1'b0;
    @(negedge clk);
    chk("m1_held_occ", 32'(occ3), 32'd2);
    chk("m1_held_rdy", 32'(rr3.tready), 32'd0);
    @(posedge clk); #1;
    flush3 = 1'b1; rx3.tvalid = 1'b1; rx3.t = mk(48); tr3.tready = 1'b1;
    @(negedge clk);
    chk("m1_flush_rdy", 32'(rr3.tready), 32'd0);
    chk("m1_flush_valid", 32'(tx3.tvalid), 32'd0);
    @(posedge clk); #1;
    flush3 = 1'b0;
    @(negedge clk);
    chk("m1_flush_occ", 32'(occ3), 32'd0);
    chk("m1_flush_empty", 32'(tx3.tvalid), 32'd0);
    @(posedge clk); #1;
    rx3.tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx3.tvalid) break;
      @(posedge clk); #1;
    end
    chk("m1_post_flush_valid", 32'(tx3.tvalid), 32'd1);
    chk("m1_post_flush_beat", tx3.t, mk(48));
    @(posedge clk); #1;

`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    // 10 beats through u1 with tready low for 5 cycles while tvalid is high.
    sent = 0; rcv = 0; stall_left = 5;
    for (cyc = 0; cyc < 100 && rcv < 10; cyc++) begin
      rx1.tvalid = (sent < 10);
      rx1.t      = mk(sent);
      if (tx1.tvalid && stall_left > 0) begin
        tr1.tready = 1'b0;
        stall_left--;
      end else begin
        tr1.tready = 1'b1;
      end
      @(negedge clk);
      if (rx1.tvalid && rr1.tready) sent++;
      if (tx1.tvalid && tr1.tready) rcv++;
      @(posedge clk); #1;
    end
    rx1.tvalid = 1'b0; tr1.tready = 1'b1;
    chk("stats_beat_cnt", bc[1], 32'd10);
    chk("stats_stall_cnt", sc[1], 32'd5);
`endif

    // Fill u1 to 4 beats, then reset mid-transfer.
    tr1.tready = 1'b0; rx1.tvalid = 1'b1; rx1.t = mk(64);
    for (int i = 0; i < 20 && occ1 != 3'd4; i++) begin
      @(posedge clk); #1;
    end
    chk("rst_pre_occ", 32'(occ1), 32'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(tx1.tvalid), 32'd0);
    chk("rst_mid_occ", 32'(occ1), 32'd0);
    chk("rst_mid_rdy", 32'(rr1.tready), 32'd1);
`ifdef AXI_STREAM_CUT_PIPE_STATS_EN
    chk("rst_beat_cnt", bc[1], 32'd0);
    chk("rst_stall_cnt", sc[1], 32'd0);
`endif
    rst = 1'b0; rx1.tvalid = 1'b0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/axi_stream_cut_pipe.md
Name: axi_stream_cut_pipe

Overview:
Parametrised AXI4-Stream register chain. It places NumStages cut stages in series between an rx and a tx port. Each stage is built in one of three modes: full cut, forward-only or backward-only. The block adds a synchronous flush and an occupancy output, and sits on long stream routes between compute clusters and DMA/NoC endpoints to close timing.

Parameters:
NumStages, 1, number of cut stages in series; 0 = pure wire (rx to tx combinational, occupancy_o tied to 0, flush_i ignored)
Mode, 0, 0 = full cut (2-entry spill per stage), 1 = forward-only (valid/data registered), 2 = backward-only (ready registered)
s_chan_t, logic, AXI Stream channel struct (tdata/tstrb/tkeep/tlast/tid/tdest/tuser)
axi_stream_req_t, logic, request struct {t, tvalid}
axi_stream_rsp_t, logic, response struct {tready}
OccWidth, $clog2(2*NumStages+1), derived localparam, never overridden

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  synchronous discard of all buffered beats
rx_req_i  input  axi_stream_req_t  receiver port request
rx_rsp_o  output  axi_stream_rsp_t  receiver port response
tx_req_o  output  axi_stream_req_t  transmitter port request
tx_rsp_i  input  axi_stream_rsp_t  transmitter port response
occupancy_o  output  OccWidth  number of beats currently held

Behaviour:
- Interface: one clock (clk_i). Reset is synchronous and active-high (rst_i). All state updates happen on rising clk_i only.
- Reset: every entry is emptied. While and after reset: tx_req_o.tvalid=0, occupancy_o=0. rx_rsp_o.tready=1 in modes 0/2; in mode 1, rx_rsp_o.tready=1 whenever the chain is empty. Data registers are not reset and carry don't-care content.
- Stage k input connects to stage k-1 output. Stage 0 is the rx port; stage NumStages-1 is the tx port.
- Mode 0, per stage: entries A (output) and B (skid).
  - ready_o = !B.full; valid_o = A.full; data_o = A.
  - Accept into A when A is empty or A drains in the same cycle. Otherwise accept into B.
  - When A drains and B is full, B moves to A.
  - Capacity 2, latency 1 cycle, full throughput, no combinational path in either direction.
- Mode 1, per stage: entry R.
  - ready_o = !R.full || ready_i (combinational ready path); valid_o = R.full.
  - Capacity 1, latency 1 cycle, full throughput.
- Mode 2, per stage: entry S.
  - ready_o = !S.full (registered).
  - valid_o = S.full || valid_i; data_o = S.full ? S : data_i.
  - S captures when valid_i && !ready_i && !S.full.
  - S drains when ready_i.
  - Capacity 1, latency 0.
- Beat order is preserved. No beat is duplicated or dropped except on flush. All s_chan_t fields travel together.
- A handshake happens on tvalid && tready. Once tvalid is asserted, tvalid and t stay stable until accepted (AXIS rule, guaranteed by construction at tx).
- occupancy_o = sum of full entries, registered, updated every cycle.
  - Max value: 2*NumStages in mode 0, NumStages in modes 1/2.
  - A simultaneous rx accept and tx drain leaves the count unchanged.
- flush_i:
  - In the flush_i cycle, tx_req_o.tvalid and rx_rsp_o.tready are forced to 0 combinationally, so no handshake occurs.
  - On the next edge all entries are emptied and occupancy_o becomes 0.
  - Reset has priority over flush.
  - flush_i held high keeps the chain empty and stalled.
- Reset mid-transfer: buffered beats are discarded exactly as with flush.

Optional Feature:
Macro AXI_STREAM_CUT_PIPE_STATS_EN.
- Defined: adds output ports beat_cnt_o (32 bit), counting tx handshakes, and stall_cnt_o (32 bit), counting cycles with tx tvalid && !tready.
  - Both counters saturate at 2^32-1.
  - Both are cleared by rst_i and by flush_i.
  - Both are registered, with 1-cycle latency after the event.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Mode 0, NumStages=3, tready=1, back-to-back beats 0..99 -> first tx tvalid 3 cycles after the first rx accept; 100 beats in order, one per cycle; occupancy_o steady at 3.
- Mode 0, NumStages=2, tready=0, continuous rx tvalid -> exactly 4 beats accepted, then rx tready=0 and occupancy_o=4; release tready -> beats 0..3 in order, no bubbles.
- Mode 2, NumStages=1, tready=1 -> each beat appears at tx in the same cycle as it is accepted at rx (latency 0); drop tready for 1 cycle -> exactly one beat is held in S and occupancy_o=1.
- Mode 1, NumStages=2, holding 2 beats: pulse flush_i together with rx tvalid and tx tready -> no handshake in that cycle, occupancy_o=0 next cycle, next tx beat is the first beat sent after flush.
- Assert rst_i while occupancy_o=4 (mode 0) -> next cycle tvalid=0, occupancy_o=0; with STATS_EN both counters read 0.
- STATS_EN, Mode 0, 10 beats with tready low for 5 cycles while tvalid=1 -> beat_cnt_o=10, stall_cnt_o=5.
